// File: rtl/pipeline_pkg.sv
// Shared opcode groups, FSM encoding and constants for the pipeline hazard controller.
package pipeline_pkg;

  // Single-opcode instructions
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_RLA = 8'h01;
  localparam logic [7:0] OP_RRA = 8'h02;
  localparam logic [7:0] OP_CLR = 8'h03;
  localparam logic [7:0] OP_INA = 8'h04;
  localparam logic [7:0] OP_OUT = 8'h05;

  // Register-indexed groups: opcode[7:3] selects the group, opcode[2:0] is Rn
  localparam logic [4:0] GRP_PSH = 5'b00010;
  localparam logic [4:0] GRP_POP = 5'b00011;
  localparam logic [4:0] GRP_NOT = 5'b00110;
  localparam logic [4:0] GRP_INC = 5'b01000;
  localparam logic [4:0] GRP_DCR = 5'b01001;
  localparam logic [4:0] GRP_MVI = 5'b01011;
  localparam logic [4:0] GRP_MVD = 5'b01100;
  localparam logic [4:0] GRP_MVS = 5'b01101;
  localparam logic [4:0] GRP_STA = 5'b01110;
  localparam logic [4:0] GRP_LDA = 5'b01111;

  // ALU forms occupy 0x80..0xEF; opcode[3] set selects the immediate variant
  localparam logic [3:0] ALU_BASE = 4'h8;
  localparam logic [3:0] ALU_LAST = 4'hE;

  localparam logic [7:0] MASK_R0  = 8'h01;
  localparam logic [7:0] NOP_CTRL = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RAW      = 2'd1,
    ST_FREEZE   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  function automatic logic [7:0] reg_mask(input logic [2:0] n);
    reg_mask = 8'h01 << n;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the S2 opcode into register read and write masks.
module hazard_decode
  import pipeline_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [7:0] rd,
  output logic [7:0] wr
);

  logic [7:0] rn;
  logic       n_nz;

  assign rn   = reg_mask(opcode[2:0]);
  assign n_nz = |opcode[2:0];

  always_comb begin
    rd = NOP_CTRL;
    wr = NOP_CTRL;
    if (opcode[7:4] >= ALU_BASE && opcode[7:4] <= ALU_LAST) begin
      rd = opcode[3] ? MASK_R0 : (MASK_R0 | rn);
      wr = MASK_R0;
    end else begin
      case (opcode[7:3])
        GRP_NOT, GRP_INC, GRP_DCR: begin
          rd = rn;
          wr = rn;
        end
        GRP_MVI, GRP_POP: wr = rn;
        GRP_PSH:          rd = rn;
        GRP_LDA:          if (n_nz) wr = rn;
        GRP_STA:          if (n_nz) rd = rn;
        GRP_MVD: if (n_nz) begin
          rd = MASK_R0;
          wr = rn;
        end
        GRP_MVS: if (n_nz) begin
          rd = rn;
          wr = MASK_R0;
        end
        default: begin
          case (opcode)
            OP_RLA, OP_RRA: begin
              rd = MASK_R0;
              wr = MASK_R0;
            end
            OP_CLR, OP_INA: wr = MASK_R0;
            OP_OUT:         rd = MASK_R0;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Four-stage pipeline sequencer: RAW stall with write scoreboard, taken-transfer
// flush/redirect and whole-pipe freeze while S4 waits on memory or I/O.
module pipeline_hazard_controller
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opcode_s2,
  input  logic       valid_s2,
  input  logic       lpc_s3,
  input  logic       mem_busy,
  output logic       hold_s1,
  output logic       hold_s2,
  output logic       bubble_s3,
  output logic       freeze,
  output logic       flush,
  output logic       issue_s2,
  output logic [1:0] state
);

  state_t     cur_st, nxt_st;
  logic [7:0] pend3, pend4;
  logic [7:0] rd, wr;
  logic       raw;

  hazard_decode u_decode (
    .opcode (opcode_s2),
    .rd     (rd),
    .wr     (wr)
  );

  assign raw   = valid_s2 & |(rd & (pend3 | pend4));
  assign state = cur_st;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st <= ST_RUN;
      pend3  <= NOP_CTRL;
      pend4  <= NOP_CTRL;
    end else begin
      cur_st <= nxt_st;
      if (!freeze) begin
        pend4 <= pend3;
        pend3 <= issue_s2 ? wr : NOP_CTRL;
      end
    end
  end

  // A held lpc_s3 in frozen S3 is serviced as soon as mem_busy drops.
  always_comb begin
    nxt_st    = ST_RUN;
    hold_s1   = 1'b0;
    hold_s2   = 1'b0;
    bubble_s3 = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    issue_s2  = 1'b0;
    if (rst) begin
      nxt_st = ST_RUN;
    end else if (mem_busy) begin
      freeze  = 1'b1;
      hold_s1 = 1'b1;
      hold_s2 = 1'b1;
      nxt_st  = ST_FREEZE;
    end else if (lpc_s3) begin
      flush     = 1'b1;
      bubble_s3 = 1'b1;
      nxt_st    = ST_REDIRECT;
    end else if (cur_st == ST_REDIRECT) begin
      bubble_s3 = 1'b1;
      nxt_st    = ST_RUN;
    end else if (raw) begin
      hold_s1   = 1'b1;
      hold_s2   = 1'b1;
      bubble_s3 = 1'b1;
      nxt_st    = ST_RAW;
    end else begin
      // An empty S2 still feeds a NOP control word into S3.
      issue_s2  = valid_s2;
      bubble_s3 = ~valid_s2;
      nxt_st    = ST_RUN;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller: hand-derived per-cycle
// expected outputs are queued at drive time and compared at mid-cycle.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] opcode_s2;
  logic       valid_s2, lpc_s3, mem_busy;
  logic       hold_s1, hold_s2, bubble_s3, freeze, flush, issue_s2;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  pipeline_hazard_controller dut (
    .clk       (clk),
    .rst       (rst),
    .opcode_s2 (opcode_s2),
    .valid_s2  (valid_s2),
    .lpc_s3    (lpc_s3),
    .mem_busy  (mem_busy),
    .hold_s1   (hold_s1),
    .hold_s2   (hold_s2),
    .bubble_s3 (bubble_s3),
    .freeze    (freeze),
    .flush     (flush),
    .issue_s2  (issue_s2),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packs {hold_s1, hold_s2, bubble_s3, freeze, flush, issue_s2, state}
  function automatic logic [7:0] ex(input logic h1, input logic h2, input logic b,
                                    input logic fz, input logic fl, input logic is,
                                    input logic [1:0] st);
    ex = {h1, h2, b, fz, fl, is, st};
  endfunction

  task automatic step(input string tag, input logic r, input logic [7:0] op,
                      input logic v, input logic l, input logic b, input logic [7:0] e);
    rst       = r;
    opcode_s2 = op;
    valid_s2  = v;
    lpc_s3    = l;
    mem_busy  = b;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    #4;
    chk(tag_q.pop_front(), {hold_s1, hold_s2, bubble_s3, freeze, flush, issue_s2, state},
        exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic pchk(input string tag, input logic [7:0] p3, input logic [7:0] p4);
    chk({tag, "_pend3"}, dut.pend3, p3);
    chk({tag, "_pend4"}, dut.pend4, p4);
  endtask

  initial begin
    rst = 1'b1; opcode_s2 = 8'h00; valid_s2 = 1'b0; lpc_s3 = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pchk("reset", 8'h00, 8'h00);

    step("idle_after_rst", 0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));
    // INC R3 then ADA R3: two stall cycles
    step("inc_r3",     0, 8'h43, 1, 0, 0, ex(0,0,0,0,0,1,0));
    step("ada_stall1", 0, 8'h83, 1, 0, 0, ex(1,1,1,0,0,0,0));
    step("ada_stall2", 0, 8'h83, 1, 0, 0, ex(1,1,1,0,0,0,1));
    step("ada_issue",  0, 8'h83, 1, 0, 0, ex(0,0,0,0,0,1,1));
    pchk("after_ada", 8'h01, 8'h00);
    step("drain1", 0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));
    step("drain2", 0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));
    // ADI, NOP, ORA R1: one stall cycle
    step("adi",       0, 8'h88, 1, 0, 0, ex(0,0,0,0,0,1,0));
    step("nop",       0, 8'h00, 1, 0, 0, ex(0,0,0,0,0,1,0));
    step("ora_stall", 0, 8'hD1, 1, 0, 0, ex(1,1,1,0,0,0,0));
    step("ora_issue", 0, 8'hD1, 1, 0, 0, ex(0,0,0,0,0,1,1));
    // Taken transfer while ADA R3 is also RAW-stalled on R0: lpc wins
    step("lpc_flush",   0, 8'h83, 1, 1, 0, ex(0,0,1,0,1,0,0));
    step("redirect",    0, 8'h83, 1, 0, 0, ex(0,0,1,0,0,0,3));
    pchk("after_redirect", 8'h00, 8'h00);
    // Independent MVI R1, MVI R2
    step("mvi_r1", 0, 8'h59, 1, 0, 0, ex(0,0,0,0,0,1,0));
    step("mvi_r2", 0, 8'h5A, 1, 0, 0, ex(0,0,0,0,0,1,0));
    pchk("after_mvi", 8'h04, 8'h02);
    step("drain3", 0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));
    step("drain4", 0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));
    // mem_busy for 3 cycles in the middle of a 2-cycle RAW stall
    step("inc_r3_b",   0, 8'h43, 1, 0, 0, ex(0,0,0,0,0,1,0));
    step("raw_b1",     0, 8'h83, 1, 0, 0, ex(1,1,1,0,0,0,0));
    step("frz1",       0, 8'h83, 1, 0, 1, ex(1,1,0,1,0,0,1));
    step("frz2",       0, 8'h83, 1, 0, 1, ex(1,1,0,1,0,0,2));
    pchk("frozen", 8'h00, 8'h08);
    step("frz3",       0, 8'h83, 1, 0, 1, ex(1,1,0,1,0,0,2));
    pchk("after_frz", 8'h00, 8'h08);
    step("raw_b2",     0, 8'h83, 1, 0, 0, ex(1,1,1,0,0,0,2));
    step("ada_issue_b",0, 8'h83, 1, 0, 0, ex(0,0,0,0,0,1,1));
    // Reset pulsed during REDIRECT
    step("lpc2",       0, 8'h00, 0, 1, 0, ex(0,0,1,0,1,0,0));
    step("rst_in_redir", 1, 8'h00, 0, 0, 0, ex(0,0,0,0,0,0,3));
    pchk("after_rst", 8'h00, 8'h00);
    step("post_rst",   0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));
    // lpc held behind mem_busy, serviced when busy drops
    step("busy_lpc",   0, 8'h83, 1, 1, 1, ex(1,1,0,1,0,0,0));
    step("lpc_late",   0, 8'h83, 1, 1, 0, ex(0,0,1,0,1,0,2));
    step("redirect2",  0, 8'h83, 1, 0, 0, ex(0,0,1,0,0,0,3));
    step("run_again",  0, 8'h00, 0, 0, 0, ex(0,0,1,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
